// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes and datapath select codes.
// Build option CTRL_JTYPE_EN (see multicycle_ctrl) decides whether S_JAL is reachable.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_LUI      = 4'd10,
    S_JAL      = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decode from funct3/funct7b5; flags funct3 values the datapath cannot execute.
// Purely combinational, zero latency, no handshake.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_is_rtype,
  output logic [2:0] o_alu_control,
  output logic       o_unsupported
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_unsupported = 1'b0;
    case (i_funct3)
      3'b000:  o_alu_control = (i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  o_alu_control = ALU_SLT;
      3'b110:  o_alu_control = ALU_OR;
      3'b111:  o_alu_control = ALU_AND;
      default: o_unsupported = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core; stalls on mem_ready, ERROR is terminal until reset.
// Define CTRL_JTYPE_EN to include the JAL sequence; otherwise op 1101111 is treated as illegal.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ResultSrc,
  output logic       illegal
);

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] w_alu_control;
  logic       w_alu_unsupported;

  alu_decoder u_alu_decoder (
    .i_funct3      (funct3),
    .i_funct7b5    (funct7b5),
    .i_is_rtype    (op == OP_RTYPE),
    .o_alu_control (w_alu_control),
    .o_unsupported (w_alu_unsupported)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= state_t'(RESET_STATE);
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_BEQ:            w_next_state = S_BEQ;
          OP_LUI:            w_next_state = S_LUI;
`ifdef CTRL_JTYPE_EN
          OP_JAL:            w_next_state = S_JAL;
`endif
          default:           w_next_state = S_ERROR;
        endcase
      end
      S_MEMADR:   w_next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
      S_EXECR,
      S_EXECI:    w_next_state = w_alu_unsupported ? S_ERROR : S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BEQ:      w_next_state = (funct3 == 3'b000) ? S_FETCH : S_ERROR;
      S_LUI:      w_next_state = S_ALUWB;
`ifdef CTRL_JTYPE_EN
      S_JAL:      w_next_state = S_ALUWB;
`endif
      default:    w_next_state = S_ERROR;
    endcase
  end

  // Outputs are gated by rst_n so an asserted reset kills an in-flight access at once.
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ImmSrc     = IMM_I;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    ResultSrc  = RES_ALUOUT;
    illegal    = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
          end
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
`ifdef CTRL_JTYPE_EN
          ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
`else
          ImmSrc  = IMM_B;
`endif
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_MEMDATA;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_RS2;
          ALUControl = w_alu_control;
        end
        S_EXECI: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_IMM;
          ImmSrc     = IMM_I;
          ALUControl = w_alu_control;
        end
        S_ALUWB: begin
          ResultSrc = RES_ALUOUT;
          RegWrite  = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_RS2;
          ALUControl = ALU_SUB;
          ResultSrc  = RES_ALUOUT;
          // A malformed branch must not redirect the PC on its way to ERROR.
          PCWrite    = zero && (funct3 == 3'b000);
        end
        S_LUI: begin
          ImmSrc  = IMM_U;
          ALUSrcA = SRCA_ZERO;
          ALUSrcB = SRCB_IMM;
        end
`ifdef CTRL_JTYPE_EN
        S_JAL: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALUOUT;
          PCWrite   = 1'b1;
        end
`endif
        S_ERROR:  illegal = 1'b1;
        default:  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle against hand-written expectations.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [2:0] ImmSrc, ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ResultSrc(ResultSrc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o; funct3 = f3; funct7b5 = f7;
  endtask

  // Advance to the next low phase, apply handshake inputs, let outputs settle.
  task automatic cyc(input logic mr, input logic zr);
    @(negedge clk);
    mem_ready = mr;
    zero      = zr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(dut.r_state), 32'(S_FETCH));
    chk("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fetch + decode with no memory wait, then the execute state.
  task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic [2:0] exp_ctl);
    set_instr(o, f3, f7);
    cyc(1'b1, 1'b0);
    chk({tag, "_fetch_ir"}, 32'(IRWrite), 32'd1);
    cyc(1'b1, 1'b0);
    chk({tag, "_dec_srca"}, 32'(ALUSrcA), 32'(SRCA_OLDPC));
    cyc(1'b1, 1'b0);
    chk({tag, "_exec_ctl"}, 32'(ALUControl), 32'(exp_ctl));
    chk({tag, "_exec_regw"}, 32'(RegWrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk({tag, "_wb_regw"}, 32'(RegWrite), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    set_instr(7'd0, 3'd0, 1'b0);
    #2;
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_strobes", 32'({IRWrite, PCWrite, RegWrite, MemWrite, illegal}), 32'd0);
    chk("reset_selects", 32'({ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FETCH waits on memory: request held, nothing latched.
    set_instr(OP_RTYPE, 3'b000, 1'b0);
    #1;
    chk("fetch_wait_req", 32'(mem_req), 32'd1);
    chk("fetch_wait_ir", 32'(IRWrite), 32'd0);
    // add: 4 cycles, ALUWB only writes
    cyc(1'b1, 1'b0);
    chk("add_fetch", 32'({mem_req, AdrSrc, IRWrite, PCWrite, RegWrite}), 32'b10110);
    chk("add_fetch_sel", 32'({ALUSrcA, ALUSrcB, ALUControl, ResultSrc}), 32'b00_10_000_10);
    cyc(1'b1, 1'b0);
    chk("add_dec_imm", 32'(ImmSrc), 32'(IMM_B));
    chk("add_dec_regw", 32'(RegWrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk("add_exec", 32'({ALUSrcA, ALUSrcB, ALUControl}), 32'b10_00_000);
    chk("add_exec_regw", 32'(RegWrite), 32'd0);
    cyc(1'b1, 1'b0);
    chk("add_wb", 32'({RegWrite, ResultSrc}), 32'b1_00);

    alu_instr("sub",  OP_RTYPE, 3'b000, 1'b1, ALU_SUB);
    alu_instr("addi", OP_ITYPE, 3'b000, 1'b1, ALU_ADD);
    alu_instr("slti", OP_ITYPE, 3'b010, 1'b0, ALU_SLT);
    alu_instr("or",   OP_RTYPE, 3'b110, 1'b0, ALU_OR);
    alu_instr("andi", OP_ITYPE, 3'b111, 1'b0, ALU_AND);

    // lw with three wait cycles in MEMREAD: 8 cycles total
    set_instr(OP_LOAD, 3'b010, 1'b0);
    cyc(1'b1, 1'b0);
    chk("lw_fetch_ir", 32'(IRWrite), 32'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("lw_memadr", 32'({ALUSrcA, ALUSrcB, ImmSrc}), 32'b10_01_000);
    for (int i = 0; i < 4; i++) begin
      cyc((i == 3), 1'b0);
      chk($sformatf("lw_memrd%0d", i), 32'({mem_req, AdrSrc, MemWrite, RegWrite}), 32'b1100);
    end
    cyc(1'b1, 1'b0);
    chk("lw_memwb", 32'({ResultSrc, RegWrite}), 32'b01_1);
    cyc(1'b0, 1'b0);
    chk("lw_back_fetch", 32'({mem_req, AdrSrc}), 32'b10);

    // sw with two wait cycles
    set_instr(OP_STORE, 3'b010, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("sw_memadr_imm", 32'(ImmSrc), 32'(IMM_S));
    for (int i = 0; i < 3; i++) begin
      cyc((i == 2), 1'b0);
      chk($sformatf("sw_memwr%0d", i), 32'({mem_req, MemWrite, AdrSrc, RegWrite}), 32'b1110);
    end
    cyc(1'b0, 1'b0);
    chk("sw_back_fetch", 32'({mem_req, MemWrite, AdrSrc}), 32'b100);

    // beq taken then not taken, 3 cycles each
    for (int t = 1; t >= 0; t--) begin
      set_instr(OP_BEQ, 3'b000, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, t[0]);
      chk($sformatf("beq%0d_ctl", t), 32'({ALUSrcA, ALUSrcB, ALUControl}), 32'b10_00_001);
      chk($sformatf("beq%0d_pcw", t), 32'(PCWrite), 32'(t));
      cyc(1'b0, 1'b0);
      chk($sformatf("beq%0d_fetch", t), 32'({mem_req, RegWrite}), 32'b10);
    end

    // lui
    set_instr(OP_LUI, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("lui_sel", 32'({ImmSrc, ALUSrcA, ALUSrcB, ALUControl}), 32'b011_11_01_000);
    cyc(1'b1, 1'b0);
    chk("lui_wb", 32'(RegWrite), 32'd1);

    // jal
    set_instr(OP_JAL, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
`ifdef CTRL_JTYPE_EN
    chk("jal_dec_imm", 32'(ImmSrc), 32'(IMM_J));
    cyc(1'b1, 1'b0);
    chk("jal_state", 32'({PCWrite, ALUSrcA, ALUSrcB, ResultSrc}), 32'b1_01_10_00);
    cyc(1'b1, 1'b0);
    chk("jal_wb", 32'(RegWrite), 32'd1);
    cyc(1'b0, 1'b0);
    chk("jal_fetch", 32'(mem_req), 32'd1);
`else
    chk("jal_dec_imm", 32'(ImmSrc), 32'(IMM_B));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("jal_illegal%0d", i), 32'({illegal, mem_req, PCWrite, RegWrite}), 32'b1000);
    end
    do_reset();
`endif

    // fence is unsupported: ERROR is sticky and ignores mem_ready
    set_instr(7'b0001111, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("fence_illegal%0d", i), 32'({illegal, mem_req, IRWrite, RegWrite}), 32'b1000);
    end
    set_instr(OP_RTYPE, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    chk("fence_sticky", 32'(illegal), 32'd1);
    do_reset();

    // R-type with an unimplemented funct3 ends in ERROR
    set_instr(OP_RTYPE, 3'b001, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("sll_illegal", 32'({illegal, RegWrite}), 32'b10);
    do_reset();

    // Reset in the middle of a stalled store
    set_instr(OP_STORE, 3'b000, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("sw_pre_reset", 32'({mem_req, MemWrite}), 32'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("sw_rst_req", 32'({mem_req, MemWrite}), 32'b00);
    chk("sw_rst_state", 32'(dut.r_state), 32'(S_FETCH));
    chk("sw_rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_fetch", 32'({mem_req, AdrSrc}), 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
